// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core; optional perf counters under PIPE_CTRL_PERF_EN.
// Latency: stall/flush/new_pc/bus_err are combinational from state and inputs; state updates on posedge clk.
// Backpressure: merges ID/EX/MEM stall requests into a per-stage stall vector; MEM watchdog forces a bus-error flush.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          FLUSH_HOLD  = 1,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             bus_err,
    input  logic [1:0]       perf_sel,
    output logic [CNT_W-1:0] perf_cnt
);

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;
    localparam int WD_W = $clog2(MEM_TIMEOUT);
    localparam int HD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);
    localparam logic [HD_W-1:0] HD_INIT = HD_W'(FLUSH_HOLD - 1);

    typedef enum logic {RUN, HOLD} state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd_cnt, wd_nxt;
    logic [HD_W-1:0] hd_cnt, hd_nxt;
    logic            cause_mem, cause_ex, cause_id;

    // Next-state and output decode: exception > watchdog timeout > MEM > EX > ID stall.
    always_comb begin
        stall     = 6'b000000;
        flush     = 1'b0;
        new_pc    = 32'h0000_0000;
        bus_err   = 1'b0;
        state_nxt = state;
        wd_nxt    = wd_cnt;
        hd_nxt    = hd_cnt;
        cause_mem = 1'b0;
        cause_ex  = 1'b0;
        cause_id  = 1'b0;
        if (rst) begin
            state_nxt = RUN;
            wd_nxt    = '0;
            hd_nxt    = '0;
        end else if (state == HOLD) begin
            // Post-flush holdoff: all requests ignored, pipeline runs free.
            wd_nxt = '0;
            if (hd_cnt == '0) begin
                state_nxt = RUN;
            end else begin
                hd_nxt = hd_cnt - 1'b1;
            end
        end else if (excepttype != 32'h0000_0000) begin
            flush     = 1'b1;
            new_pc    = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
            state_nxt = HOLD;
            hd_nxt    = HD_INIT;
            wd_nxt    = '0;
        end else if (stallreq_mem && (wd_cnt == WD_LAST)) begin
            flush     = 1'b1;
            bus_err   = 1'b1;
            new_pc    = EXC_VECTOR;
            state_nxt = HOLD;
            hd_nxt    = HD_INIT;
            wd_nxt    = '0;
        end else if (stallreq_mem) begin
            stall     = 6'b011111;
            wd_nxt    = wd_cnt + 1'b1;
            cause_mem = 1'b1;
        end else begin
            wd_nxt = '0;
            if (stallreq_ex) begin
                stall    = 6'b001111;
                cause_ex = 1'b1;
            end else if (stallreq_id) begin
                stall    = 6'b000111;
                cause_id = 1'b1;
            end
        end
    end

    // State, watchdog and holdoff registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            wd_cnt <= '0;
            hd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_nxt;
            hd_cnt <= hd_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cnt_mem, cnt_ex, cnt_id, cnt_flush;

    // Saturating counters: stall cycles by winning cause, and flush events.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_mem   <= '0;
            cnt_ex    <= '0;
            cnt_id    <= '0;
            cnt_flush <= '0;
        end else begin
            if (cause_mem && (cnt_mem != '1))  cnt_mem   <= cnt_mem + 1'b1;
            if (cause_ex && (cnt_ex != '1))    cnt_ex    <= cnt_ex + 1'b1;
            if (cause_id && (cnt_id != '1))    cnt_id    <= cnt_id + 1'b1;
            if (flush && (cnt_flush != '1))    cnt_flush <= cnt_flush + 1'b1;
        end
    end

    // Counter readout mux, held at zero during reset like the other outputs.
    always_comb begin
        perf_cnt = '0;
        if (!rst) begin
            case (perf_sel)
                2'd0:    perf_cnt = cnt_mem;
                2'd1:    perf_cnt = cnt_ex;
                2'd2:    perf_cnt = cnt_id;
                default: perf_cnt = cnt_flush;
            endcase
        end
    end
`else
    logic unused_perf;
    assign unused_perf = ^{perf_sel, cause_mem, cause_ex, cause_id};
    assign perf_cnt    = '0;
`endif

endmodule
